// File: rtl/zap_ifetch_port.sv
// Instruction-side Wishbone classic read port feeding the fetch stage.
// Holds the fetched word under stall, discards it on clear, and presents bus errors or timeouts as aborts.
//
// state   | meaning
// IDLE    | no bus cycle; launch a request unless cleared
// REQ     | cyc/stb high, waiting for ack/err/timeout
// DRAIN   | request cancelled by clear; finish the bus cycle and discard it
// DELIVER | word or abort presented to fetch, held while stalled
// SLEEP   | abort consumed; wait for a clear before fetching again
module zap_ifetch_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_pc,
    input  logic        i_stall,
    input  logic        i_clear,
    output logic [31:0] o_instruction,
    output logic        o_valid,
    output logic        o_instr_abort,
    output logic [31:0] o_pc_ff,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic [31:0] o_wb_adr,
    output logic [3:0]  o_wb_sel,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic        o_busy
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN,
        S_DELIVER,
        S_SLEEP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             timed_out;
    logic             unused_pc_bits;

    assign timed_out      = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES));
    assign o_wb_sel       = 4'hF;
    assign unused_pc_bits = ^i_pc[1:0];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            o_instruction <= '0;
            o_valid       <= 1'b0;
            o_instr_abort <= 1'b0;
            o_pc_ff       <= '0;
            o_wb_cyc      <= 1'b0;
            o_wb_stb      <= 1'b0;
            o_wb_adr      <= '0;
            o_busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!i_clear) begin
                        o_wb_adr <= {i_pc[31:2], 2'b00};
                        o_wb_cyc <= 1'b1;
                        o_wb_stb <= 1'b1;
                        o_busy   <= 1'b1;
                        cnt      <= '0;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_clear) begin
                        // A response landing with the clear already ended the bus cycle; nothing left to drain.
                        if (i_wb_ack || i_wb_err || timed_out) begin
                            o_wb_cyc <= 1'b0;
                            o_wb_stb <= 1'b0;
                            o_busy   <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            if (cnt != '1) cnt <= cnt + 1'b1;
                            state <= S_DRAIN;
                        end
                    end else if (i_wb_err || timed_out) begin
                        o_wb_cyc      <= 1'b0;
                        o_wb_stb      <= 1'b0;
                        o_busy        <= 1'b0;
                        o_instr_abort <= 1'b1;
                        o_valid       <= 1'b0;
                        o_instruction <= '0;
                        o_pc_ff       <= o_wb_adr;
                        state         <= S_DELIVER;
                    end else if (i_wb_ack) begin
                        o_wb_cyc      <= 1'b0;
                        o_wb_stb      <= 1'b0;
                        o_busy        <= 1'b0;
                        o_instr_abort <= 1'b0;
                        o_valid       <= 1'b1;
                        o_instruction <= i_wb_dat;
                        o_pc_ff       <= o_wb_adr;
                        state         <= S_DELIVER;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (i_wb_ack || i_wb_err || timed_out) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        o_busy   <= 1'b0;
                        state    <= S_IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DELIVER: begin
                    if (i_clear || !i_stall) begin
                        o_instruction <= '0;
                        o_valid       <= 1'b0;
                        o_instr_abort <= 1'b0;
                        o_pc_ff       <= '0;
                        if (i_clear) begin
                            state <= S_IDLE;
                        end else if (o_instr_abort) begin
                            state <= S_SLEEP;
                        end else begin
                            o_wb_adr <= {i_pc[31:2], 2'b00};
                            o_wb_cyc <= 1'b1;
                            o_wb_stb <= 1'b1;
                            o_busy   <= 1'b1;
                            cnt      <= '0;
                            state    <= S_REQ;
                        end
                    end
                end
                S_SLEEP: begin
                    if (i_clear) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
